// File: rtl/arith_result_collector.sv
// Result collector for the fixed-latency four-operand arithmetic pipeline:
// tracks accepted issues, captures F LAT cycles later and queues it in a credit-protected FIFO.
module arith_result_collector #(
  parameter int WIDTH = 10,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     issue_ready,
  input  logic [WIDTH-1:0]         f_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Wide enough to hold count + inflight without wrapping for any LAT.
  localparam int SW = $clog2(DEPTH + LAT + 1) + 1;

  logic [LAT-1:0]   v;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [SW-1:0]    inflight;
  logic             accept;
  logic             capture;
  logic             pop;

  // NOTE: combinational logic uses blocking '=' with a default assigned first, so no latch is inferred.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + SW'(v[i]);
    end
  end

  // Credit counts every stored and every in-flight result, so the FIFO can never overflow.
  assign issue_ready = (SW'(count) + inflight) < SW'(DEPTH);
  assign accept      = in_valid & issue_ready;
  assign capture     = v[LAT-1];
  assign out_valid   = (count != '0);
  assign pop         = out_valid & out_ready;
  assign out_data    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v        <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      v[0] <= accept;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
      end
      if (capture) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (in_valid && !issue_ready) drop_err <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (rst_n && capture) mem[wr_ptr] <= f_in;
  end

  overflow_never : assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && !pop && count == CW'(DEPTH)));

endmodule

// File: tb/tb_arith_result_collector.sv
// Bench for arith_result_collector: vector table, directed corner sequences and a random run
// checked against a queue-based model of the collector.
module tb_arith_result_collector;

  localparam int WIDTH = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             issue_ready;
  logic [WIDTH-1:0] f_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             drop_err;

  arith_result_collector #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .issue_ready(issue_ready),
    .f_in(f_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: FIFO contents, capture due-edges of accepted issues, sticky drop flag.
  logic [WIDTH-1:0] mq[$];
  int               due[$];
  bit               mdrop = 1'b0;
  int               cyc = 0;
  logic [WIDTH-1:0] sched [int];
  logic [WIDTH-1:0] got[$];
  bit               last_accept;
  bit               pre_ready;

  typedef struct {
    bit               iv;
    logic [WIDTH-1:0] f;
    bit               ordy;
    bit               ev;
    logic [WIDTH-1:0] ed;
    int               ec;
    bit               er;
    bit               edrop;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [WIDTH-1:0] fcalc(int a, int b, int c, int d);
    return WIDTH'(((a + b) + (c - d)) * d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, update the model at the edge, compare 1 time unit later.
  task automatic step(input bit rst, input bit iv, input logic [WIDTH-1:0] fval, input bit ordy);
    bit credit;
    @(negedge clk);
    rst_n     = !rst;
    in_valid  = iv;
    out_ready = ordy;
    if (iv) sched[cyc + LAT] = fval;
    f_in = sched.exists(cyc) ? sched[cyc] : WIDTH'($urandom);
    credit    = (mq.size() + due.size()) < DEPTH;
    pre_ready = issue_ready;
    last_accept = iv && credit && !rst;
    if (!rst && out_valid && ordy) got.push_back(out_data);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      due.delete();
      mdrop = 1'b0;
    end else begin
      if (iv && !credit) mdrop = 1'b1;
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (due.size() > 0 && due[0] == cyc) begin
        void'(due.pop_front());
        mq.push_back(f_in);
      end
      if (iv && credit) due.push_back(cyc + LAT);
    end
    cyc++;
    #1;
    check("model_count", count, mq.size());
    check("model_valid", out_valid, mq.size() != 0);
    check("model_ready", issue_ready, (mq.size() + due.size()) < DEPTH);
    check("model_drop", drop_err, mdrop);
    if (mq.size() != 0) check("model_data", out_data, mq[0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [WIDTH-1:0] f80, f120;
    int n_acc;
    int nxt;
    f80  = fcalc(5, 6, 7, 8);
    f120 = fcalc(10, 6, 7, 8);
    // iv, f, ordy | valid, data, count, ready, drop  (values after the row's edge)
    tbl[0]  = '{1, f80,  0, 0, 0,   0, 1, 0};
    tbl[1]  = '{0, 0,    0, 0, 0,   0, 1, 0};
    tbl[2]  = '{0, 0,    0, 0, 0,   0, 1, 0};
    tbl[3]  = '{0, 0,    0, 1, 80,  1, 1, 0};
    tbl[4]  = '{0, 0,    1, 0, 0,   0, 1, 0};
    tbl[5]  = '{1, f80,  1, 0, 0,   0, 1, 0};
    tbl[6]  = '{1, f120, 1, 0, 0,   0, 1, 0};
    tbl[7]  = '{1, f80,  1, 0, 0,   0, 1, 0};
    tbl[8]  = '{0, 0,    1, 1, 80,  1, 1, 0};
    tbl[9]  = '{0, 0,    1, 1, 120, 1, 1, 0};
    tbl[10] = '{0, 0,    1, 1, 80,  1, 1, 0};
    tbl[11] = '{0, 0,    1, 0, 0,   0, 1, 0};

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("reset_valid", out_valid, 0);
    check("reset_count", count, 0);
    check("reset_drop", drop_err, 0);
    check("reset_ready", issue_ready, 1);

    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].iv, tbl[i].f, tbl[i].ordy);
      check($sformatf("vec%0d_valid", i), out_valid, tbl[i].ev);
      check($sformatf("vec%0d_count", i), count, tbl[i].ec);
      check($sformatf("vec%0d_ready", i), issue_ready, tbl[i].er);
      check($sformatf("vec%0d_drop", i), drop_err, tbl[i].edrop);
      if (tbl[i].ev) check($sformatf("vec%0d_data", i), out_data, tbl[i].ed);
    end

    // Credit stall: consumer blocked, issue attempted every cycle.
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, WIDTH'(11 + i), 0);
      n_acc += int'(pre_ready);
      if (i == 3) check("stall_drop_after4", drop_err, 0);
      if (i == 4) check("stall_drop_after5", drop_err, 1);
    end
    check("stall_accepted", n_acc, 4);
    check("stall_count", count, 4);
    check("stall_ready", issue_ready, 0);
    check("stall_head", out_data, 11);

    // Push and pop on one edge. Credit keeps count+inflight <= DEPTH, so count==DEPTH with a
    // capture pending cannot occur; the overlap is exercised one below full with a wrapped tail.
    step(0, 0, 0, 1);
    check("pp_count_after_pop", count, 3);
    step(0, 1, 99, 0);
    check("pp_issue_accepted", last_accept, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    got.delete();
    step(0, 0, 0, 1);
    check("pp_count_held", count, 3);
    check("pp_head_advanced", out_data, 13);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    check("pp_drained", count, 0);
    check("pp_n_out", got.size(), 4);
    if (got.size() == 4) begin
      check("pp_out0", got[0], 12);
      check("pp_out1", got[1], 13);
      check("pp_out2", got[2], 14);
      check("pp_out3", got[3], 99);
    end

    // Reset one cycle before the first capture; drop_err is still set from the stall.
    step(0, 1, 200, 0);
    step(0, 1, 201, 0);
    step(1, 0, 0, 0);
    check("rst_ready", issue_ready, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_drop", drop_err, 0);

    // Wrap-around: 1..10 through the FIFO with out_ready toggling.
    got.delete();
    nxt = 1;
    for (int t = 0; t < 200 && got.size() < 10; t++) begin
      step(0, nxt <= 10, WIDTH'(nxt), t[0]);
      if (last_accept) nxt++;
    end
    check("wrap_n_out", got.size(), 10);
    for (int i = 0; i < got.size() && i < 10; i++) check($sformatf("wrap_out%0d", i), got[i], i + 1);

    // Random traffic with occasional resets.
    for (int t = 0; t < 400; t++) begin
      step(($urandom % 50) == 0, $urandom_range(0, 1), WIDTH'($urandom), ($urandom % 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
